// File: rtl/prnhead_data_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : prnhead_data_arb_if
// Description : Request/grant/strobe bundle between the print-data and command
//               requesters and the printhead data-mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface prnhead_data_arb_if;
  logic [7:0] PrintHead_Type;
  logic       prn_req;
  logic [7:0] prn_len;
  logic       cmd_req;
  logic [3:0] cmd_len;
  logic       abort;
  logic       prn_gnt;
  logic       prn_done;
  logic       cmd_gnt;
  logic       cmd_done;
  logic       aborted;
  logic       Prndata_en;
  logic       CMD_en;
  logic       busy;

  // Requester side: raises requests, watches grants and strobes
  modport master (
    output PrintHead_Type, prn_req, prn_len, cmd_req, cmd_len, abort,
    input  prn_gnt, prn_done, cmd_gnt, cmd_done, aborted, Prndata_en, CMD_en, busy
  );

  // Arbiter side
  modport slave (
    input  PrintHead_Type, prn_req, prn_len, cmd_req, cmd_len, abort,
    output prn_gnt, prn_done, cmd_gnt, cmd_done, aborted, Prndata_en, CMD_en, busy
  );
endinterface
`default_nettype wire

// File: rtl/prnhead_data_arb.sv
`default_nettype none
// ============================================================================
// Module      : prnhead_data_arb
// Description : Arbiter/sequencer for the 4-bit printhead data mux. Print data
//               has priority, a starvation counter forces commands through,
//               and a head-type dependent idle gap separates bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module prnhead_data_arb #(
  parameter int STARVE_LIM = 16,
  parameter int GAP_CYC    = 2
) (
  input logic               clk,
  input logic               rstn,
  prnhead_data_arb_if.slave bus
);

  localparam int c_SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam int c_GW = (GAP_CYC > 0) ? $clog2(2 * GAP_CYC + 1) : 1;
  localparam logic [c_SW-1:0] c_STARVE_LIM = c_SW'(STARVE_LIM);
  localparam logic [c_GW-1:0] c_GAP_1      = c_GW'(GAP_CYC);
  localparam logic [c_GW-1:0] c_GAP_2      = c_GW'(2 * GAP_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRN  = 2'd1,
    S_CMD  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_beat, w_beat_nxt;          // beats left after the current one
  logic [c_GW-1:0] r_gap, w_gap_nxt;            // gap cycles left after the current one
  logic [c_SW-1:0] r_starve_cnt, w_starve_nxt;
  logic            r_prn_gnt, w_prn_gnt_nxt;
  logic            r_prn_done, w_prn_done_nxt;
  logic            r_cmd_gnt, w_cmd_gnt_nxt;
  logic            r_cmd_done, w_cmd_done_nxt;
  logic            r_aborted, w_aborted_nxt;
  logic            r_prn_en, w_prn_en_nxt;
  logic            r_cmd_en, w_cmd_en_nxt;
  logic            r_busy;

  logic            w_starve_flag;
  logic            w_cmd_grant;
  logic [c_GW-1:0] w_gap_len;
  logic [7:0]      w_prn_last;                  // clamped length minus one
  logic [7:0]      w_cmd_last;

  assign w_starve_flag = (r_starve_cnt == c_STARVE_LIM);
  assign w_gap_len     = (bus.PrintHead_Type == 8'h04) ? c_GAP_2 : c_GAP_1;
  assign w_prn_last    = (bus.prn_len == 8'd0) ? 8'd0 : bus.prn_len - 8'd1;
  assign w_cmd_last    = (bus.cmd_len == 4'd0) ? 8'd0 : {4'd0, bus.cmd_len - 4'd1};

  // Next-state, counter and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_nxt     = r_beat;
    w_gap_nxt      = r_gap;
    w_prn_gnt_nxt  = 1'b0;
    w_prn_done_nxt = 1'b0;
    w_cmd_gnt_nxt  = 1'b0;
    w_cmd_done_nxt = 1'b0;
    w_aborted_nxt  = 1'b0;
    w_prn_en_nxt   = 1'b0;
    w_cmd_en_nxt   = 1'b0;
    w_cmd_grant    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_starve_flag && bus.cmd_req) || (bus.cmd_req && !bus.prn_req)) begin
          w_cmd_grant = 1'b1;
        end else if (bus.prn_req) begin
          w_state_nxt    = S_PRN;
          w_beat_nxt     = w_prn_last;
          w_prn_gnt_nxt  = 1'b1;
          w_prn_en_nxt   = 1'b1;
          w_prn_done_nxt = (w_prn_last == 8'd0);
        end
        if (w_cmd_grant) begin
          w_state_nxt    = S_CMD;
          w_beat_nxt     = w_cmd_last;
          w_cmd_gnt_nxt  = 1'b1;
          w_cmd_en_nxt   = 1'b1;
          w_cmd_done_nxt = (w_cmd_last == 8'd0);
        end
      end
      S_PRN, S_CMD: begin
        // Last beat takes precedence over a coincident abort
        if (r_beat == 8'd0) begin
          if (w_gap_len != '0) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = w_gap_len - 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (bus.abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
        end else begin
          w_beat_nxt = r_beat - 8'd1;
          if (r_state == S_PRN) begin
            w_prn_en_nxt   = 1'b1;
            w_prn_done_nxt = (r_beat == 8'd1);
          end else begin
            w_cmd_en_nxt   = 1'b1;
            w_cmd_done_nxt = (r_beat == 8'd1);
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Starvation counter: counts waiting cycles, saturates, clears on command grant
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_cmd_grant) begin
      w_starve_nxt = '0;
    end else if ((r_state == S_IDLE) && !bus.cmd_req) begin
      w_starve_nxt = '0;
    end else if (bus.cmd_req && (r_state != S_CMD) && !w_starve_flag) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end
  end

  // State, counters and all outputs registered; reset may cut a burst short
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_beat       <= 8'd0;
      r_gap        <= '0;
      r_starve_cnt <= '0;
      r_prn_gnt    <= 1'b0;
      r_prn_done   <= 1'b0;
      r_cmd_gnt    <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_aborted    <= 1'b0;
      r_prn_en     <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_beat       <= w_beat_nxt;
      r_gap        <= w_gap_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_prn_gnt    <= w_prn_gnt_nxt;
      r_prn_done   <= w_prn_done_nxt;
      r_cmd_gnt    <= w_cmd_gnt_nxt;
      r_cmd_done   <= w_cmd_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_prn_en     <= w_prn_en_nxt;
      r_cmd_en     <= w_cmd_en_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.prn_gnt    = r_prn_gnt;
  assign bus.prn_done   = r_prn_done;
  assign bus.cmd_gnt    = r_cmd_gnt;
  assign bus.cmd_done   = r_cmd_done;
  assign bus.aborted    = r_aborted;
  assign bus.Prndata_en = r_prn_en;
  assign bus.CMD_en     = r_cmd_en;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire
